// File: rtl/md_unit.sv
// md_unit: multiply/divide unit with architectural HI/LO registers for the
// MIPS execute stage. Signed/unsigned multiply and divide run as 32-step
// iterative sequences on operand magnitudes, with a final sign fixup cycle.
// mthi/mtlo write HI/LO directly in one cycle.
// Optional feature macro: MD_FAST_MUL_EN. When it is defined, mult/multu
// complete in a single cycle and never raise busy; divide stays iterative.

module md_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   input  logic [2:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ITER,
      ST_FIN
   } state_t;

   state_t      state;
   logic [4:0]  count;
   // Shared accumulator: multiply keeps {partial product, multiplier},
   // divide keeps {partial remainder, dividend/quotient shift register}.
   logic [63:0] acc;
   // Multiplicand magnitude for multiply, divisor magnitude for divide.
   logic [31:0] operand;
   logic        is_div;
   logic        neg_q;
   logic        neg_r;
   logic        div_zero;
   logic [31:0] orig_a;

   logic        accept;
   logic        is_signed_op;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [32:0] mul_sum;
   logic [32:0] partial;
   logic        div_ok;
   logic [31:0] div_diff;
   logic [63:0] iter_next;
   logic [63:0] prod_fix;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

`ifdef MD_FAST_MUL_EN
   logic [63:0] fast_a;
   logic [63:0] fast_b;
   logic [63:0] fast_prod;
`endif

   // Accept decision, operand magnitudes and one iteration step of the datapath.
   always_comb begin
      accept       = op_valid & ~busy & ~rst;
      is_signed_op = (op == OP_MULT) | (op == OP_DIV);
      abs_a        = (is_signed_op & src_a[31]) ? (32'd0 - src_a) : src_a;
      abs_b        = (is_signed_op & src_b[31]) ? (32'd0 - src_b) : src_b;

      // Shift-add: add multiplicand when the current multiplier bit is set,
      // then shift the whole accumulator right by one.
      mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);

      // Restoring divide: bring in the next dividend bit, try a 33-bit subtract.
      partial  = acc[63:31];
      div_ok   = (partial >= {1'b0, operand});
      div_diff = acc[62:31] - operand;

      if (is_div) begin
         iter_next = div_ok ? {div_diff, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
      end else begin
         iter_next = {mul_sum, acc[31:1]};
      end

      prod_fix = neg_q ? (64'd0 - acc) : acc;
      quo_fix  = neg_q ? (32'd0 - acc[31:0]) : acc[31:0];
      rem_fix  = neg_r ? (32'd0 - acc[63:32]) : acc[63:32];
   end

`ifdef MD_FAST_MUL_EN
   // Single-cycle product of the 33-bit sign/zero-extended operands, kept to 64 bits.
   always_comb begin
      fast_a    = {{32{(op == OP_MULT) & src_a[31]}}, src_a};
      fast_b    = {{32{(op == OP_MULT) & src_b[31]}}, src_b};
      fast_prod = fast_a * fast_b;
   end
`endif

   // Control FSM, operand latching, iteration and HI/LO writeback.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         count    <= 5'd0;
         acc      <= 64'd0;
         operand  <= 32'd0;
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         orig_a   <= 32'd0;
         hi       <= 32'd0;
         lo       <= 32'd0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (accept) begin
                  case (op)
`ifdef MD_FAST_MUL_EN
                     OP_MULT, OP_MULTU: {hi, lo} <= fast_prod;
                     OP_DIV, OP_DIVU: begin
`else
                     OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
`endif
                        state    <= ST_ITER;
                        busy     <= 1'b1;
                        count    <= 5'd0;
                        is_div   <= op[1];
                        acc      <= {32'd0, (op[1] ? abs_a : abs_b)};
                        operand  <= op[1] ? abs_b : abs_a;
                        neg_q    <= is_signed_op & (src_a[31] ^ src_b[31]);
                        neg_r    <= is_signed_op & src_a[31];
                        div_zero <= op[1] & (src_b == 32'd0);
                        orig_a   <= src_a;
                     end
                     OP_MTHI: hi <= src_a;
                     OP_MTLO: lo <= src_a;
                     default: ;
                  endcase
               end
            end
            ST_ITER: begin
               acc   <= iter_next;
               count <= count + 5'd1;
               if (count == 5'd31) begin
                  state <= ST_FIN;
                  done  <= 1'b1;
               end
            end
            ST_FIN: begin
               if (is_div) begin
                  if (div_zero) begin
                     lo <= 32'hFFFF_FFFF;
                     hi <= orig_a;
                  end else begin
                     lo <= quo_fix;
                     hi <= rem_fix;
                  end
               end else begin
                  {hi, lo} <= prod_fix;
               end
               state <= ST_IDLE;
               count <= 5'd0;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit with architectural HI/LO registers for the MIPS pipeline. It sits in the execute stage, directly downstream of the instruction decoder. It consumes the decoded stage-3 instructions mult, multu, div, divu, mthi and mtlo, together with the rs/rt operand values, and it supplies HI/LO to the writeback mux for mfhi and mflo. Division always runs as an iterative radix-2 restoring sequence, and the pipeline stalls on `busy`.

## Interface
Parameters:
- none; datapath width is fixed at 32 bits, HI/LO at 32 bits each.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `op_valid` in 1: an operation is presented this cycle.
- `op` in 3: 3'b000 mult, 3'b001 multu, 3'b010 div, 3'b011 divu, 3'b100 mthi, 3'b101 mtlo; 3'b110 and 3'b111 are no-ops.
- `src_a` in 32: rs value (multiplicand or dividend; mthi/mtlo data).
- `src_b` in 32: rt value (multiplier or divisor; ignored for mthi/mtlo).
- `busy` out 1: iterative operation in progress; new ops are not accepted.
- `done` out 1: one-cycle pulse in the final cycle of an iterative operation.
- `hi` out 32: HI register; direct register output.
- `lo` out 32: LO register; direct register output.

## Operation
- Accept rule: `accept = op_valid & ~busy & ~rst`. While `busy`=1, `op_valid` is ignored; upstream holds the instruction (stall).
- States:
  - IDLE
  - ITER: 32 cycles, 5-bit counter 0..31.
  - FIN: 1 cycle.
- `busy = (state != IDLE)`.
- IDLE transitions:
  - accepted mult, multu, div or divu -> ITER, counter=0.
  - accepted mthi: `hi <= src_a`; stays in IDLE.
  - accepted mtlo: `lo <= src_a`; stays in IDLE.
  - accepted op 110/111: no effect.
- Operand latch (signed ops): on accept, latch |src_a|, |src_b|, the quotient/product sign (sign_a XOR sign_b) and the remainder sign (sign_a).
- Operand latch (unsigned ops): operands latched as-is, signs forced positive.
- ITER, multiply: 32-step shift-add on the magnitudes into a 64-bit accumulator.
- ITER, divide: 32-step restoring division on the magnitudes, one quotient bit per cycle, with a 33-bit partial-remainder subtract.
- ITER -> FIN when counter==31.
- FIN: `done`=1. Sign fixup is two's-complement negation:
  - multiply: negate the 64-bit product if the product sign is set; `{hi,lo} <= product`.
  - divide: negate the quotient if the quotient sign is set, and the remainder if the remainder sign is set; `lo <= quotient`, `hi <= remainder`.
- FIN -> IDLE.
- Divide by zero (src_b==0, div or divu): full latency still applies; result is `lo=32'hFFFFFFFF`, `hi=src_a` (original value, no sign fixup).
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives `lo=32'h80000000`, `hi=0`, as the magnitude arithmetic produces naturally.
- mfhi/mflo read `hi`/`lo` directly; a read during `busy` returns the old value. The decoder/hazard logic stalls mfhi/mflo while `busy`=1.

## Timing
- Reset: at a `rst` edge, state=IDLE, counter=0, `hi`=0, `lo`=0, `busy`=0, `done`=0. An in-flight operation is discarded. `rst` has priority over `op_valid`.
- mthi/mtlo: presented in cycle 0; the new value is visible in cycle 1; `busy` is never asserted.
- Iterative mult/div: presented in cycle 0, accepted at the end of cycle 0.
  - `busy`=1 in cycles 1..33.
  - `done`=1 in cycle 33.
  - HI/LO updated at the end of cycle 33 and visible in cycle 34, when `busy`=0.
- Back-to-back: a new op presented in cycle 34 is accepted at the end of cycle 34.
- An op held through cycles 1..33 is accepted at the end of the first cycle in which `busy`=0.

## Configuration
- `MD_FAST_MUL_EN`, when defined:
  - mult/multu compute a single-cycle 33x33 signed product (operands sign- or zero-extended).
  - `{hi,lo}` is written at the accept edge; the state stays IDLE, so `busy` and `done` are never asserted for multiply.
  - Result is visible in cycle 1.
- `MD_FAST_MUL_EN`, when undefined: multiply uses the iterative ITER/FIN path with the 34-cycle latency above.
- Divide is iterative in both configurations.

## Test plan
- multu 0xFFFFFFFF x 0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001 in cycle 34 (cycle 1 with `MD_FAST_MUL_EN`); mult -3 x 5 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
- div -7 / 2 -> `busy` high in cycles 1..33, `done` pulse in cycle 33, `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF in cycle 34; divu 100/7 -> `lo`=14, `hi`=2.
- div 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0; divu 5/0 -> `lo`=0xFFFFFFFF, `hi`=5 after 34 cycles.
- mthi 0x12345678 while idle -> `hi`=0x12345678 next cycle, `busy` stays 0; mtlo 0xAAAA presented with `op_valid` held during a divide -> `lo` shows the divide result in cycle 34, then 0xAAAA in cycle 35.
- Assert `rst` in cycle 10 of a divu -> cycle 11: `busy`=0, `hi`=`lo`=0, `done` never pulses; mult presented in cycle 11 is accepted immediately.
